// File: rtl/fir_mc_pkg.sv
// fir_mc_pkg: shared types and arithmetic helpers for the multi-channel FIR accelerator.
//   state_e    : controller states IDLE / MAC / RESULT
//   acc_width  : accumulator width for a given sample width and tap count
//   ch_width   : channel index width (at least 1 bit)
//   sat_shift  : arithmetic right shift (optionally rounded), clip to a signed
//                range of 'width' bits, and report whether clipping occurred
package fir_mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        RESULT = 2'd2
    } state_e;

    // Working widths for sat_shift. The accumulator is sign-extended into
    // ACC_MAX bits, so acc_width() must not exceed ACC_MAX and WIDTH must stay
    // below DATA_MAX.
    localparam int ACC_MAX  = 128;
    localparam int DATA_MAX = 64;

    typedef struct packed {
        logic [DATA_MAX-1:0] data;
        logic                sat;
    } sat_res_t;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic sat_res_t sat_shift(input logic signed [ACC_MAX-1:0] acc,
                                           input int                        shift,
                                           input int                        width,
                                           input logic                      round_en);
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] r;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        sat_res_t                  res;
        one = {{(ACC_MAX-1){1'b0}}, 1'b1};
        // Rounding adds half an output LSB before the shift (round half up).
        // The wide working width keeps this addition from overflowing.
        if (round_en && shift > 0)
            r = (acc + (one <<< (shift - 1))) >>> shift;
        else
            r = acc >>> shift;
        hi = (one <<< (width - 1)) - one;
        lo = -(one <<< (width - 1));
        if (r > hi) begin
            res.data = hi[DATA_MAX-1:0];
            res.sat  = 1'b1;
        end else if (r < lo) begin
            res.data = lo[DATA_MAX-1:0];
            res.sat  = 1'b1;
        end else begin
            res.data = r[DATA_MAX-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mc_accel_mac.sv
// fir_mc_mac: single signed multiply-accumulate lane with saturating output stage.
//   clk     in   clock
//   clear   in   zero the accumulator (takes priority over en)
//   en      in   add sample*coeff to the accumulator this cycle
//   sample  in   signed sample
//   coeff   in   signed coefficient
//   r_data  out  shifted + clipped value of (acc + sample*coeff), i.e. the sum
//                including the product presented this cycle
//   r_sat   out  r_data was clipped
// Build option: FIR_MC_ROUND_EN selects round-half-up before the shift;
// otherwise the shift truncates toward minus infinity.
module fir_mc_mac
    import fir_mc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] coeff,
    output logic [WIDTH-1:0] r_data,
    output logic             r_sat
);

    localparam int ACC_W = acc_width(WIDTH, TAPS);

`ifdef FIR_MC_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic signed [WIDTH-1:0]   sample_s;
    logic signed [WIDTH-1:0]   coeff_s;
    logic signed [2*WIDTH-1:0] prod_p0;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [ACC_W-1:0]   acc_next;
    sat_res_t                  res;
    logic [DATA_MAX-WIDTH-1:0] unused_res_hi;

    assign sample_s = sample;
    assign coeff_s  = coeff;
    assign prod_p0  = sample_s * coeff_s;
    assign acc_next = acc_p1 + {{(ACC_W-2*WIDTH){prod_p0[2*WIDTH-1]}}, prod_p0};

    // ---- accumulator stage ----
    always_ff @(posedge clk) begin
        if (clear)
            acc_p1 <= '0;
        else if (en)
            acc_p1 <= acc_next;
    end

    assign res           = sat_shift({{(ACC_MAX-ACC_W){acc_next[ACC_W-1]}}, acc_next},
                                     OUT_SHIFT, WIDTH, ROUND_EN);
    assign r_data        = res.data[WIDTH-1:0];
    assign r_sat         = res.sat;
    assign unused_res_hi = res.data[DATA_MAX-1:WIDTH];

endmodule

// File: rtl/fir_mc_accel.sv
// fir_mc_accel: time-multiplexed multi-channel FIR. One MAC processes one tap
// per cycle for the channel of the most recently accepted sample; all channels
// share one double-buffered (shadow/active) coefficient set.
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             sample handshake (in_ready only in IDLE)
//   in_chan, in_data              channel index and signed sample
//   out_valid/out_ready           result handshake, result held until taken
//   out_chan, out_data, out_sat   result channel, clipped value, clip flag
//   coeff_wr_en/addr/data         shadow coefficient write (addr 0 = newest)
//   coeff_commit                  copy shadow to active (deferred while busy)
//   err_chan                      sticky flag: out-of-range channel seen
// Build option: FIR_MC_ROUND_EN (see fir_mc_mac) enables rounding before the
// output shift.
module fir_mc_accel
    import fir_mc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAPS      = 8,
    parameter int CHANNELS  = 4,
    parameter int OUT_SHIFT = 0,
    localparam int CH_W     = ch_width(CHANNELS),
    localparam int AW       = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_chan,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_chan,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    input  logic             coeff_wr_en,
    input  logic [AW-1:0]    coeff_wr_addr,
    input  logic [WIDTH-1:0] coeff_wr_data,
    input  logic             coeff_commit,
    output logic             err_chan
);

    state_e           state;
    logic [CH_W-1:0]  cur_chan;
    logic [AW-1:0]    cur_ptr;
    logic [AW-1:0]    tap;
    logic [AW-1:0]    wp      [CHANNELS];
    logic [WIDTH-1:0] hist    [CHANNELS][TAPS];
    logic [WIDTH-1:0] shadow  [TAPS];
    logic [WIDTH-1:0] shadow_next [TAPS];
    logic [WIDTH-1:0] active  [TAPS];
    logic             pending;

    logic             accept;
    logic             chan_ok;
    logic             last_tap;
    logic             enter_idle;
    logic             load_active;
    logic [WIDTH-1:0] r_data;
    logic             r_sat;

    assign accept     = in_valid && in_ready;
    assign chan_ok    = int'(in_chan) < CHANNELS;
    assign last_tap   = (state == MAC) && (tap == AW'(TAPS - 1));
    assign enter_idle = (state == RESULT) && out_ready;

    fir_mc_mac #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk    (clk),
        .clear  (accept && chan_ok),
        .en     (state == MAC),
        .sample (hist[cur_chan][cur_ptr]),
        .coeff  (active[tap]),
        .r_data (r_data),
        .r_sat  (r_sat)
    );

    // Controller: in_ready is registered, so it is low through reset and rises
    // on the first clock edge after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            err_chan  <= 1'b0;
            cur_chan  <= '0;
            cur_ptr   <= '0;
            tap       <= '0;
            for (int c = 0; c < CHANNELS; c++)
                wp[c] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (chan_ok) begin
                            state    <= MAC;
                            in_ready <= 1'b0;
                            cur_chan <= in_chan;
                            cur_ptr  <= wp[in_chan];
                            tap      <= '0;
                            wp[in_chan] <= (wp[in_chan] == AW'(TAPS - 1)) ?
                                           '0 : wp[in_chan] + AW'(1);
                        end else begin
                            // Out-of-range channel: swallow the sample, flag it.
                            err_chan <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    tap     <= tap + AW'(1);
                    // Walk backwards from the newest sample of this channel.
                    cur_ptr <= (cur_ptr == '0) ? AW'(TAPS - 1) : cur_ptr - AW'(1);
                    if (last_tap) begin
                        state     <= RESULT;
                        out_valid <= 1'b1;
                        out_chan  <= cur_chan;
                        out_data  <= r_data;
                        out_sat   <= r_sat;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sample histories.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < TAPS; k++)
                    hist[c][k] <= '0;
        end else if (accept && chan_ok) begin
            hist[in_chan][wp[in_chan]] <= in_data;
        end
    end

    // Shadow bank as it will be after this cycle's write, so a commit in the
    // same cycle as a write picks the new value up.
    always_comb begin
        for (int k = 0; k < TAPS; k++)
            shadow_next[k] = shadow[k];
        if (coeff_wr_en && int'(coeff_wr_addr) < TAPS)
            shadow_next[coeff_wr_addr] = coeff_wr_data;
    end

    // Active set only changes in IDLE or on the edge that returns to IDLE, so
    // a result in flight always sees one coherent coefficient set. A commit in
    // the same IDLE cycle as an accept lands first because the MAC reads the
    // active bank from the next cycle on.
    assign load_active = ((state == IDLE) && coeff_commit) ||
                         (enter_idle && (pending || coeff_commit));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++)
                shadow[k] <= shadow_next[k];
            if (load_active) begin
                for (int k = 0; k < TAPS; k++)
                    active[k] <= shadow_next[k];
            end
            if (enter_idle)
                pending <= 1'b0;
            else if (state != IDLE && coeff_commit)
                pending <= 1'b1;
        end
    end

endmodule
